// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between fetch and load/store. Grants and responses route combinationally (0 cycles added).
// Data has priority, but fetch is forced through after STARVE_MAX consecutive data wins. Reads stall while MAX_OUT are in flight; writes never stall.
module unified_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iReq,
  input  logic [DATA_W-1:0]         iAddr,
  output logic                      iGnt,
  output logic                      iRvalid,
  output logic [DATA_W-1:0]         iRdata,
  input  logic                      dReq,
  input  logic                      dWen,
  input  logic [DATA_W-1:0]         dAddr,
  input  logic [DATA_W-1:0]         dWdata,
  input  logic [2:0]                dSize,
  output logic                      dGnt,
  output logic                      dRvalid,
  output logic [DATA_W-1:0]         dRdata,
  output logic                      memReq,
  output logic                      memWen,
  output logic [DATA_W-1:0]         memAddr,
  output logic [DATA_W-1:0]         memWdata,
  output logic [2:0]                memSize,
  input  logic                      memReady,
  input  logic                      memRvalid,
  input  logic [DATA_W-1:0]         memRdata,
  output logic [$clog2(MAX_OUT):0]  outCount,
  output logic                      respErr
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  logic [MAX_OUT-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               err_q, err_d;

  logic full, pick_i, pick_d, is_read, grant, push, pop, head_tag;

  always_comb begin
    full    = (cnt_q == CNT_W'(MAX_OUT));
    pick_i  = iReq && (!dReq || (starve_q == SW'(STARVE_MAX)));
    pick_d  = dReq && !pick_i;
    is_read = pick_i || (pick_d && !dWen);
    // A pop this cycle does not free a slot until the next cycle.
    grant   = (pick_i || pick_d) && memReady && !(is_read && full);
    iGnt    = grant && pick_i;
    dGnt    = grant && pick_d;
  end

  always_comb begin
    memReq   = grant;
    memWen   = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    memSize  = 3'b000;
    if (iGnt) begin
      memAddr = iAddr;
      memSize = 3'b010;
    end else if (dGnt) begin
      memWen   = dWen;
      memAddr  = dAddr;
      memWdata = dWdata;
      memSize  = dSize;
    end
  end

  always_comb begin
    push     = grant && is_read;
    pop      = memRvalid && (cnt_q != '0);
    head_tag = tag_q[rd_ptr_q];
    iRvalid  = pop && !head_tag;
    dRvalid  = pop && head_tag;
    iRdata   = iRvalid ? memRdata : '0;
    dRdata   = dRvalid ? memRdata : '0;
    outCount = cnt_q;
    respErr  = err_q;
  end

  always_comb begin
    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q] = pick_d;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q || (memRvalid && (cnt_q == '0));
    starve_d = starve_q;
    if (iGnt || !iReq) begin
      starve_d = '0;
    end else if (dGnt && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: queue-based reference model checked every negedge, plus directed literal checks.
module tb_unified_mem_arbiter;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int SM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          iReq = 1'b0, dReq = 1'b0, dWen = 1'b0;
  logic [DW-1:0] iAddr = '0, dAddr = '0, dWdata = '0, memRdata = '0;
  logic [2:0]    dSize = 3'b000;
  logic          memReady = 1'b0, memRvalid = 1'b0;
  logic          iGnt, iRvalid, dGnt, dRvalid, memReq, memWen, respErr;
  logic [DW-1:0] iRdata, dRdata, memAddr, memWdata;
  logic [2:0]    memSize;
  logic [2:0]    outCount;

  unified_mem_arbiter #(.DATA_W(DW), .MAX_OUT(MO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
    .dReq(dReq), .dWen(dWen), .dAddr(dAddr), .dWdata(dWdata), .dSize(dSize),
    .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
    .memReq(memReq), .memWen(memWen), .memAddr(memAddr), .memWdata(memWdata),
    .memSize(memSize), .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata),
    .outCount(outCount), .respErr(respErr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner queue (0=fetch, 1=data), starvation count, sticky error.
  bit mq[$];
  int m_starve = 0;
  bit m_err = 0;

  always @(negedge clk) begin : model
    bit fetch_wins, want, rd, ok, gi, gd, owner, resp;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_size;
    if (!rst) begin
      mq.delete();
      m_starve = 0;
      m_err = 0;
    end
    want = iReq || dReq;
    fetch_wins = iReq && (!dReq || m_starve == SM);
    rd   = fetch_wins ? 1'b1 : (dReq && !dWen);
    ok   = want && memReady && !(rd && mq.size() == MO);
    gi   = ok && fetch_wins;
    gd   = ok && !fetch_wins;
    e_addr  = gi ? iAddr : (gd ? dAddr : 32'h0);
    e_wdata = gd ? dWdata : 32'h0;
    e_size  = gi ? 3'b010 : (gd ? dSize : 3'b000);
    resp  = memRvalid && mq.size() > 0;
    owner = resp ? mq[0] : 1'b0;
    chk("iGnt", iGnt, gi);
    chk("dGnt", dGnt, gd);
    chk("memReq", memReq, ok);
    chk("memWen", memWen, gd && dWen);
    chk("memAddr", memAddr, e_addr);
    chk("memWdata", memWdata, e_wdata);
    chk("memSize", memSize, e_size);
    chk("iRvalid", iRvalid, resp && !owner);
    chk("dRvalid", dRvalid, resp && owner);
    chk("iRdata", iRdata, (resp && !owner) ? memRdata : 32'h0);
    chk("dRdata", dRdata, (resp && owner) ? memRdata : 32'h0);
    chk("outCount", outCount, mq.size());
    chk("respErr", respErr, m_err);
    if (rst) begin
      if (memRvalid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (ok && rd) mq.push_back(gd);
      if (gi || !iReq) m_starve = 0;
      else if (gd && m_starve < SM) m_starve++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0] pat;
    logic [4:0] fg;
    pat = '0;
    fg  = '0;
    // Reset state
    tick(); tick();
    #1;
    chk("rst_outCount", outCount, 0);
    chk("rst_respErr", respErr, 0);
    chk("rst_memReq", memReq, 0);
    chk("rst_grants", {iGnt, dGnt, iRvalid, dRvalid}, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single fetch and its response
    iReq = 1'b1; iAddr = 32'h100; memReady = 1'b1;
    #1;
    chk("f1_iGnt", iGnt, 1);
    chk("f1_memAddr", memAddr, 32'h100);
    chk("f1_memWen", memWen, 0);
    tick();
    chk("f1_cnt1", outCount, 1);
    iReq = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
    #1;
    chk("f1_iRvalid", iRvalid, 1);
    chk("f1_iRdata", iRdata, 32'hDEADBEEF);
    tick();
    memRvalid = 1'b0;
    chk("f1_cnt0", outCount, 0);

    // Starvation: both reading, responses every cycle
    iReq = 1'b1; dReq = 1'b1; dWen = 1'b0; iAddr = 32'h200; dAddr = 32'h40;
    for (int k = 0; k < 8; k++) begin
      memRvalid = (k > 0);
      memRdata  = 32'hA000 + k;
      #1;
      pat[k] = iGnt;
      if (k == 4) begin
        chk("st_route_i", iRvalid, 1);
        chk("st_route_d", iRdata, 32'hA004);
      end
      tick();
    end
    iReq = 1'b0; dReq = 1'b0; memRvalid = 1'b1; memRdata = 32'hA008;
    tick();
    memRvalid = 1'b0;
    chk("st_pattern", pat, 8'b1000_1000);
    chk("st_cnt0", outCount, 0);

    // Fill to MAX_OUT with fetches
    iReq = 1'b1; iAddr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      #1;
      fg[k] = iGnt;
      tick();
    end
    chk("full_pattern", fg, 5'b01111);
    chk("full_cnt", outCount, 4);
    iReq = 1'b0; dReq = 1'b1; dWen = 1'b1; dAddr = 32'h20; dWdata = 32'h55;
    #1;
    chk("wr_dGnt", dGnt, 1);
    chk("wr_memWen", memWen, 1);
    chk("wr_memAddr", memAddr, 32'h20);
    chk("wr_memWdata", memWdata, 32'h55);
    tick();
    dReq = 1'b0; dWen = 1'b0;
    chk("wr_cnt", outCount, 4);

    // Pop while full does not free a slot in the same cycle
    iReq = 1'b1; memRvalid = 1'b1; memRdata = 32'h1111;
    #1;
    chk("pf_iGnt0", iGnt, 0);
    chk("pf_iRvalid", iRvalid, 1);
    tick();
    memRvalid = 1'b0;
    chk("pf_cnt3", outCount, 3);
    chk("pf_iGnt1", iGnt, 1);
    tick();
    iReq = 1'b0;
    chk("pf_cnt4", outCount, 4);
    memRvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      memRdata = 32'h2000 + k;
      tick();
    end
    memRvalid = 1'b0;
    chk("drain_cnt", outCount, 0);

    // Reset mid-burst, then a late response
    iReq = 1'b1;
    tick();
    iReq = 1'b0; dReq = 1'b1;
    tick();
    dReq = 1'b0;
    chk("rb_cnt2", outCount, 2);
    rst = 1'b0;
    #1;
    chk("rb_cnt_rst", outCount, 0);
    tick();
    rst = 1'b1;
    tick();
    memRvalid = 1'b1; memRdata = 32'hBAD;
    #1;
    chk("rb_no_rvalid", {iRvalid, dRvalid}, 0);
    tick();
    memRvalid = 1'b0;
    chk("rb_respErr", respErr, 1);
    tick(); tick(); tick();
    chk("rb_respErr_sticky", respErr, 1);
    chk("rb_cnt_end", outCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port memory between the pipeline's instruction-fetch port and its load/store data port. Each cycle it grants at most one request, tracks outstanding reads in an in-order tag FIFO, and routes each read response back to its owner. Data accesses have priority; a starvation counter guarantees forward progress for fetch. Sits between the core's imem/dmem ports and the shared memory model/controller.

Parameters:
DATA_W, 32, data and address width
MAX_OUT, 4, maximum outstanding reads (tag FIFO depth, power of 2, 2..8)
STARVE_MAX, 3, consecutive data grants allowed while fetch waits before fetch is forced

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
iReq  in  1  fetch read request
iAddr  in  DATA_W  fetch address
iGnt  out  1  fetch request accepted this cycle
iRvalid  out  1  fetch read data valid
iRdata  out  DATA_W  fetch read data
dReq  in  1  data request
dWen  in  1  1=write, 0=read
dAddr  in  DATA_W  data address
dWdata  in  DATA_W  write data
dSize  in  3  access size/sign code, passed through unchanged
dGnt  out  1  data request accepted this cycle
dRvalid  out  1  load data valid
dRdata  out  DATA_W  load data
memReq  out  1  request to memory
memWen  out  1  write enable to memory
memAddr  out  DATA_W  memory address
memWdata  out  DATA_W  memory write data
memSize  out  3  memory access size
memReady  in  1  memory can accept a request this cycle
memRvalid  in  1  memory read response valid (in order, >=1 cycle after accept)
memRdata  in  DATA_W  memory read response data
outCount  out  clog2(MAX_OUT)+1  number of outstanding reads
respErr  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset (rst=0, async): tag FIFO empty, outCount=0, starveCnt=0, respErr=0. Grant/valid outputs are combinational and are 0 whenever their requests are 0.
- canIssue = memReady && !(full && read would be issued). full = (outCount==MAX_OUT). Writes are never blocked by full.
- Arbitration (combinational, same cycle): if only iReq -> fetch. If only dReq -> data. If both -> data, unless starveCnt==STARVE_MAX -> fetch. Selected request is granted only if memReady, and for reads only if !full (a pop in the same cycle does NOT free a slot for that cycle's grant). If the data read is blocked by full, fetch is also blocked (fetch is a read).
- When a grant is issued: memReq=1 and mem* signals mirror the winner (fetch: memWen=0, memSize=3'b010 (word), memWdata=0). When there is no grant: memReq=0 and all mem* signals are 0.
- starveCnt: +1 (saturating at STARVE_MAX) when data granted while iReq=1; cleared on fetch grant or when iReq=0.
- Tag FIFO: push owner bit (0=fetch, 1=data) on every granted read; pop on memRvalid. Push and pop in the same cycle leave outCount unchanged. Pointers wrap mod MAX_OUT.
- Response routing (combinational, zero added latency): on memRvalid with FIFO non-empty, head tag 0 -> iRvalid=1, iRdata=memRdata; tag 1 -> dRvalid=1, dRdata=memRdata. Inactive Rdata outputs are 0.
- memRvalid with FIFO empty: response dropped, no Rvalid, respErr set; respErr clears only on reset.
- Reset mid-operation clears FIFO; late responses after reset release therefore set respErr (expected and documented).
- Single write and read ordering is preserved by the memory; the arbiter does not reorder.

Test Plan:
- Reset with iReq=dReq=memRvalid=0 -> all outputs 0, outCount=0, respErr=0.
- iReq=1, iAddr=0x100, memReady=1; memRvalid next cycle with memRdata=0xDEADBEEF -> iGnt=1, memAddr=0x100, memWen=0; then iRvalid=1, iRdata=0xDEADBEEF, outCount 1->0.
- iReq=dReq=1 held, all reads, STARVE_MAX=3, memReady=1, responses returned each cycle -> grants D,D,D,I,D,D,D,I; responses routed to matching port in order.
- memReady=1, no responses, 5 consecutive fetch reads with MAX_OUT=4 -> 4 grants, outCount=4, 5th iGnt=0; a dReq write (dWen=1, dAddr=0x20, dWdata=0x55) in the same state -> dGnt=1, memWen=1, outCount stays 4.
- outCount=4, memRvalid=1 and iReq=1 in the same cycle -> pop occurs, iGnt=0 that cycle, outCount=3; next cycle iGnt=1, outCount=4.
- Two reads outstanding, assert rst low mid-burst, release, then memRvalid=1 -> outCount=0 and no Rvalid; respErr=1 and remains 1.
